md_unit: RTL
============

// Module: md_unit
// PURPOSE
//  Multi-cycle multiply/divide unit with its own HI/LO register pair, sitting in the
//  EX stage beside the single-cycle ALU. Accepts one mult/div per start pulse,
//  sequences it over a fixed latency, and raises busy so the hazard unit stalls
//  dependent md instructions. Also services mthi/mtlo writes and mfhi/mflo reads.
// PARAMETERS
//  MULT_CYCLES  5   cycles busy is high for MULT/MULTU (>=1)
//  DIV_CYCLES   10  cycles busy is high for DIV/DIVU (>=1)
// PORTS
//  clk     in   1   clock, all state updates on rising edge
//  reset   in   1   asynchronous, active-high; clears all state
//  start   in   1   one-cycle issue pulse for MULT/MULTU/DIV/DIVU in md_op
//  md_op   in   4   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 MFHI,8 MFLO,
//                   9 MADD,10 MADDU,11 MSUB,12 MSUBU (9-12 only with MDU_MADD_EN)
//  A       in   32  rs operand
//  B       in   32  rt operand
//  busy    out  1   operation in flight
//  hi      out  32  HI register
//  lo      out  32  LO register
//  rd      out  32  read data: hi when md_op=MFHI, lo when md_op=MFLO, else 0
// BEHAVIOUR
//  - Reset: hi=0, lo=0, busy=0, counter=0, pending results=0; reset mid-operation
//    aborts it, HI/LO are NOT written with the aborted result.
//  - States: IDLE, RUN. IDLE->RUN on start with md_op in {1..4,9..12 if enabled};
//    counter loaded with MULT_CYCLES (mult/madd family) or DIV_CYCLES (div family).
//  - Issue cycle T: operands latched, full result computed into pending hi/lo regs.
//    busy=1 for cycles T+1..T+N; counter decrements each cycle in RUN; at the edge
//    closing T+N HI/LO <= pending, state->IDLE. New HI/LO visible and busy=0 at T+N+1.
//  - MULT: {hi,lo}=$signed(A)*$signed(B) 64-bit. MULTU: unsigned 64-bit product.
//  - DIV: lo=$signed(A)/$signed(B), hi=$signed(A)%$signed(B) (remainder sign = A).
//    DIVU: unsigned quotient/remainder. B==0: still busy for DIV_CYCLES, HI/LO kept.
//  - MTHI/MTLO (start not required): hi<=A / lo<=A at next edge, only when IDLE
//    and not start; ignored while busy.
//  - MFHI/MFLO: combinational rd; returns current hi/lo (pre-update while busy).
//  - start while busy or start with a non-md op: ignored, no state change.
//  - start and MTHI/MTLO cannot coincide (single md_op); start wins by decode.
//  - Hazard unit must stall a D-stage md instruction when (start|busy); unit itself
//    does not stall or queue.
// CONFIGURATION
//  MDU_MADD_EN defined: ops 9-12 accepted; MADD {hi,lo}+=signed A*B, MADDU +=
//    unsigned, MSUB/MSUBU -= product, 64-bit wrap-around, accumulator base sampled
//    at issue, latency MULT_CYCLES.
//  MDU_MADD_EN undefined: ops 9-12 decode as NONE; start with them is ignored.
// TESTING
//  1 reset; A=-3,B=7 MULT start @T -> busy=1 T+1..T+5, @T+6 hi=32'hFFFFFFFF,
//    lo=32'hFFFFFFEB, busy=0.
//  2 A=32'hFFFFFFF9,B=2 DIVU -> busy 10 cycles, lo=32'h7FFFFFFC, hi=1; same as DIV
//    -> lo=32'hFFFFFFFD (-3), hi=32'hFFFFFFFF (-1).
//  3 hi=5,lo=6 then DIV A=9,B=0 -> busy 10 cycles, hi=5, lo=6 unchanged.
//  4 MULTU 32'hFFFFFFFF*2 in flight, reset at T+3 -> busy=0,hi=lo=0 at once, stays 0.
//  5 MTHI A=32'h1234 while busy -> hi unchanged; after idle MTHI -> hi=32'h1234,
//    MFHI rd=32'h1234 same cycle; second start at T+2 of a MULT ignored.
//  6 MDU_MADD_EN: hi=0,lo=32'hFFFFFFFF, MADDU A=1,B=1 -> hi=1,lo=0; without macro
//    same stimulus -> busy stays 0, HI/LO unchanged.

Source files
------------

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO pair, fixed-latency sequencing and mfhi/mflo read port.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are compiled in when MDU_MADD_EN is defined.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd,
  output logic        state_dbg
);

  // Handshake: start is a one-cycle issue pulse that is accepted only while busy=0;
  // a pulse seen while busy=1 (or carrying a non-md op) is dropped, never queued.

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MFHI  = 4'd7;
  localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd9;
  localparam logic [3:0] OP_MADDU = 4'd10;
  localparam logic [3:0] OP_MSUB  = 4'd11;
  localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

  state_t      state, state_nxt;
  logic [31:0] count;
  logic [63:0] pend;
  logic [63:0] pend_nxt;
  logic        is_mul, is_div, issue;

  logic [63:0] prod_s, prod_u, acc;
  logic [31:0] quo_s, rem_s, quo_u, rem_u;

  // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply equal the signed product.
  assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign prod_u = {32'b0, A} * {32'b0, B};
  assign acc    = {hi, lo};

  always_comb begin
    quo_s = 32'b0;
    rem_s = 32'b0;
    quo_u = 32'b0;
    rem_u = 32'b0;
    if (B != 32'b0) begin
      quo_s = $signed(A) / $signed(B);
      rem_s = $signed(A) % $signed(B);
      quo_u = A / B;
      rem_u = A % B;
    end
  end

  // Divide by zero keeps the current HI/LO as the pending result, so retirement rewrites the same values.
  always_comb begin
    is_mul   = 1'b0;
    is_div   = 1'b0;
    pend_nxt = acc;
    case (md_op)
      OP_MULT:  begin is_mul = 1'b1; pend_nxt = prod_s; end
      OP_MULTU: begin is_mul = 1'b1; pend_nxt = prod_u; end
      OP_DIV:   begin is_div = 1'b1; if (B != 32'b0) pend_nxt = {rem_s, quo_s}; end
      OP_DIVU:  begin is_div = 1'b1; if (B != 32'b0) pend_nxt = {rem_u, quo_u}; end
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; pend_nxt = acc + prod_s; end
      OP_MADDU: begin is_mul = 1'b1; pend_nxt = acc + prod_u; end
      OP_MSUB:  begin is_mul = 1'b1; pend_nxt = acc - prod_s; end
      OP_MSUBU: begin is_mul = 1'b1; pend_nxt = acc - prod_u; end
`endif
      default: ;
    endcase
  end

  assign issue = start && (state == IDLE) && (is_mul || is_div);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE: if (issue) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (count == 32'd1) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign state_dbg = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi    <= 32'b0;
      lo    <= 32'b0;
      pend  <= 64'b0;
      count <= 32'b0;
    end else if (issue) begin
      pend  <= pend_nxt;
      count <= is_div ? 32'(DIV_CYCLES) : 32'(MULT_CYCLES);
    end else if (state == RUN) begin
      count <= count - 32'd1;
      if (count == 32'd1) {hi, lo} <= pend;
    end else if (!start) begin
      if (md_op == OP_MTHI) hi <= A;
      if (md_op == OP_MTLO) lo <= A;
    end
  end

  always_comb begin
    rd = 32'b0;
    if (md_op == OP_MFHI) rd = hi;
    if (md_op == OP_MFLO) rd = lo;
  end

endmodule
